wf_led_event_blink: RTL and testbench
=====================================

WF_LED_EVENT_BLINK -- requirements
Module: wf_led_event_blink

Interface
REQ-001 Parameter ON_TICKS, default 10; LED-on duration in tick_en pulses, range 1..255.
REQ-002 Parameter OFF_TICKS, default 10; dark gap between consecutive blinks in tick_en pulses, range 1..255.
REQ-003 Parameter MAX_PENDING, default 7; maximum number of queued blinks, range 1..15.
REQ-004 clk  input  1  main clock; the block SHALL use this single clock, with all state updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick_en  input  1  single-cycle timebase pulse, nominally every 10 ms.
REQ-007 event_pulse  input  1  single-cycle, clk-synchronous request for one blink, e.g. a debounced switch_pushed.
REQ-008 led_n  output  1  registered, active-low LED drive; 0 means lit.
REQ-009 busy  output  1  registered; high in states ON and GAP.
REQ-010 pending  output  4  registered count of queued blinks not yet started.
REQ-011 overflow  output  1  registered single-cycle pulse when a blink request is dropped.

Function
REQ-012 The FSM SHALL have three states: IDLE, ON and GAP; led_n SHALL be 0 only in ON.
REQ-013 In IDLE, event_pulse=1 or pending!=0 SHALL move the FSM to ON at the next edge, load tick_cnt=ON_TICKS and consume one request.
REQ-014 A request SHALL be consumed from event_pulse when pending==0 and from pending otherwise, decrementing pending by 1.
REQ-015 Latency: event_pulse at edge N in IDLE with pending==0 SHALL give led_n=0 and busy=1 after edge N+1.
REQ-016 In ON or GAP, tick_en=1 SHALL decrement tick_cnt; tick_en=1 with tick_cnt==1 SHALL end the state at that edge.
REQ-017 ON SHALL end into GAP with tick_cnt=OFF_TICKS.
REQ-018 GAP SHALL end into ON with tick_cnt=ON_TICKS and one request consumed if pending!=0, otherwise into IDLE.
REQ-019 ON SHALL span exactly ON_TICKS tick_en pulses, and GAP exactly OFF_TICKS; the first tick period MAY be partial.
REQ-020 event_pulse while busy, or while in IDLE with pending!=0, SHALL increment pending.
REQ-021 pending SHALL saturate at MAX_PENDING; event_pulse at saturation with no consume in the same cycle SHALL assert overflow for one cycle with pending unchanged.
REQ-022 Simultaneous event_pulse and consume-from-pending SHALL leave pending unchanged, with no overflow.
REQ-023 tick_en in IDLE SHALL be ignored; tick_cnt SHALL be 8 bits and never wrap below 1 while active.

Reset
REQ-024 On reset=1, the block SHALL asynchronously enter IDLE with led_n=1, busy=0, pending=0, overflow=0 and tick_cnt=0.
REQ-025 Reset asserted mid-blink or mid-gap SHALL discard all queued requests; no blink SHALL resume after release.
REQ-026 After reset release, event_pulse SHALL be honoured from the first rising edge of clk.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ON=2'd1, GAP=2'd2) and the default ON_TICKS, OFF_TICKS and MAX_PENDING constants.
REQ-028 The saturating pending counter SHALL be a sub-module named wf_sat_counter, with inc, dec, count and overflow ports.
REQ-029 Encoding 2'd3 SHALL be unreachable and SHALL recover to IDLE at the next edge.

Verification
Bench settings: ON_TICKS=2, OFF_TICKS=1, MAX_PENDING=3, tick_en every 4 clocks.
REQ-030 One event_pulse in IDLE -> led_n=0 one edge later; lit until the 2nd subsequent tick_en; 1 tick dark; then IDLE with busy=0.
REQ-031 Three event_pulses 1 clock apart -> three blinks separated by GAP; pending reads 1, then 2, then 0 after the 3rd ON starts; no overflow.
REQ-032 Five event_pulses while busy -> pending=3; overflow pulses exactly twice; exactly three queued blinks follow the current one.
REQ-033 event_pulse coincident with the GAP->ON consume at pending=3 -> pending stays 3; overflow=0.
REQ-034 reset asserted mid-ON with pending=2 -> led_n=1, pending=0, busy=0 immediately; no LED activity after release until a new event_pulse.
REQ-035 tick_en held 0 for 1000 clocks in ON -> led_n remains 0 and tick_cnt unchanged.

Source files
------------

// File: rtl/wf_led_event_blink_pkg.sv
// wf_led_event_blink_pkg: shared FSM encoding and default timing/queue constants
package wf_led_event_blink_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam int ON_TICKS_DEF    = 10;
   localparam int OFF_TICKS_DEF   = 10;
   localparam int MAX_PENDING_DEF = 7;
endpackage

// File: rtl/wf_sat_counter.sv
// wf_sat_counter: saturating up/down request counter with a dropped-request pulse
module wf_sat_counter
   import wf_led_event_blink_pkg::*;
#(
   parameter int MAX = MAX_PENDING_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] count,
   output logic       overflow
);
   logic full;
   assign full = count == 4'(MAX);
   // a simultaneous inc and dec cancel, so a consume frees the slot the new request takes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= inc && !dec && full;
         if (inc && !dec && !full)
            count <= count + 4'd1;
         else if (dec && !inc && count != 4'd0)
            count <= count - 4'd1;
      end
   end
endmodule

// File: rtl/wf_led_event_blink.sv
// wf_led_event_blink: queues event pulses and plays each one as a timed LED blink plus gap
module wf_led_event_blink
   import wf_led_event_blink_pkg::*;
#(
   parameter int ON_TICKS    = ON_TICKS_DEF,
   parameter int OFF_TICKS   = OFF_TICKS_DEF,
   parameter int MAX_PENDING = MAX_PENDING_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_en,
   input  logic       event_pulse,
   output logic       led_n,
   output logic       busy,
   output logic [3:0] pending,
   output logic       overflow
);
   logic [1:0] state, state_nx;
   logic [7:0] tick_cnt, cnt_nx;
   logic       has_pend, last_tick, consume, inc;
   assign has_pend  = pending != 4'd0;
   assign last_tick = tick_en && tick_cnt <= 8'd1;
   assign inc       = event_pulse && (state == ST_ON || state == ST_GAP || (state == ST_IDLE && has_pend));
   always_comb begin
      state_nx = state;
      cnt_nx   = tick_cnt;
      consume  = 1'b0;
      case (state)
         ST_IDLE: if (event_pulse || has_pend) begin
            state_nx = ST_ON;
            cnt_nx   = 8'(ON_TICKS);
            consume  = has_pend;
         end
         ST_ON: if (last_tick) begin
            state_nx = ST_GAP;
            cnt_nx   = 8'(OFF_TICKS);
         end else if (tick_en) begin
            cnt_nx = tick_cnt - 8'd1;
         end
         ST_GAP: if (last_tick) begin
            state_nx = has_pend ? ST_ON : ST_IDLE;
            cnt_nx   = has_pend ? 8'(ON_TICKS) : 8'd0;
            consume  = has_pend;
         end else if (tick_en) begin
            cnt_nx = tick_cnt - 8'd1;
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = 8'd0;
         end
      endcase
   end
   // outputs are decoded from the next state so they are true flops, aligned with state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         tick_cnt <= 8'd0;
         led_n    <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         tick_cnt <= cnt_nx;
         led_n    <= state_nx != ST_ON;
         busy     <= state_nx == ST_ON || state_nx == ST_GAP;
      end
   end
   wf_sat_counter #(.MAX(MAX_PENDING)) u_pend (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc),
      .dec      (consume),
      .count    (pending),
      .overflow (overflow)
   );
endmodule

// File: tb/tb_wf_led_event_blink.sv
// tb_wf_led_event_blink: randomized scoreboard bench against a blink-period reference model
module tb_wf_led_event_blink;
   localparam int ON   = 2;
   localparam int OFF  = 1;
   localparam int MAXP = 3;
   typedef struct packed {
      logic       led_n;
      logic       busy;
      logic [3:0] pending;
      logic       overflow;
   } exp_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_en = 1'b0;
   logic       event_pulse = 1'b0;
   logic       led_n, busy, overflow;
   logic [3:0] pending;
   exp_t       exp_q[$];
   int         checks = 0;
   int         passed = 0;
   int         cyc = 0;
   int         hits = 0;
   bit         tick_on = 1'b1;
   bit         m_active = 1'b0;
   bit         m_ovf = 1'b0;
   int         m_idx = 0;
   int         m_queued = 0;
   always #5 clk = ~clk;
   wf_led_event_blink #(.ON_TICKS(ON), .OFF_TICKS(OFF), .MAX_PENDING(MAXP)) dut (
      .clk         (clk),
      .reset       (reset),
      .tick_en     (tick_en),
      .event_pulse (event_pulse),
      .led_n       (led_n),
      .busy        (busy),
      .pending     (pending),
      .overflow    (overflow)
   );
   // reference: a blink is one period of ON+OFF ticks; m_idx counts ticks elapsed in it
   function automatic void model(bit rst, bit ev, bit tk);
      bit want_queue;
      want_queue = ev;
      m_ovf = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         m_idx    = 0;
         m_queued = 0;
         return;
      end
      if (!m_active) begin
         if (ev || m_queued > 0) begin
            m_active = 1'b1;
            m_idx    = 0;
            if (m_queued > 0) m_queued--;
            else want_queue = 1'b0;
         end
      end else if (tk) begin
         m_idx++;
         if (m_idx == ON + OFF) begin
            if (m_queued > 0) begin
               m_queued--;
               m_idx = 0;
            end else m_active = 1'b0;
         end
      end
      if (want_queue) begin
         if (m_queued < MAXP) m_queued++;
         else m_ovf = 1'b1;
      end
   endfunction
   function automatic exp_t expect_now();
      return '{led_n: !(m_active && m_idx < ON), busy: m_active, pending: 4'(m_queued), overflow: m_ovf};
   endfunction
   function automatic void chk(string name, int act, int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endfunction
   task automatic step(input bit ev, input bit ev_on_consume = 1'b0, input bit rst_v = 1'b0);
      bit tk, e;
      @(negedge clk);
      tk = tick_on && (cyc % 4 == 3);
      cyc++;
      e = ev || (ev_on_consume && m_active && tk && m_idx == ON + OFF - 1 && m_queued == MAXP);
      if (ev_on_consume && e) hits++;
      reset       = rst_v;
      event_pulse = e;
      tick_en     = tk;
      model(rst_v, e, tk);
      exp_q.push_back(expect_now());
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({led_n, busy, pending, overflow} !== e) begin
               $display("FAIL cycle_outputs @%0t: got led_n=%b busy=%b pending=%0d overflow=%b expected led_n=%b busy=%b pending=%0d overflow=%b",
                        $time, led_n, busy, pending, overflow, e.led_n, e.busy, e.pending, e.overflow);
            end else passed++;
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1);
   end
   initial begin
      repeat (3) step(0, 0, 1);
      repeat (2) step(0);
      step(1);
      repeat (20) step(0);
      step(1); step(0); step(1); step(0); step(1);
      repeat (40) step(0);
      step(1); step(0);
      repeat (5) step(1);
      repeat (80) step(0);
      step(1);
      repeat (3) step(1);
      repeat (40) step(0, 1);
      chk("coincident_consume_hits", int'(hits > 0), 1);
      repeat (100) step(0);
      step(1); step(1); step(1);
      step(0, 0, 1);
      #1;
      chk("async_reset_led_n", int'(led_n), 1);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_pending", int'(pending), 0);
      chk("async_reset_overflow", int'(overflow), 0);
      chk("async_reset_tick_cnt", int'(dut.tick_cnt), 0);
      step(0, 0, 1);
      repeat (30) step(0);
      tick_on = 1'b0;
      step(1);
      repeat (1000) step(0);
      chk("hold_led_n", int'(led_n), 0);
      chk("hold_tick_cnt", int'(dut.tick_cnt), ON - m_idx);
      tick_on = 1'b1;
      repeat (30) step(0);
      repeat (1500) step($urandom_range(0, 5) == 0);
      step(0, 0, 1);
      step(1);
      repeat (20) step(0);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
